fifo_flow_ctrl: RTL and testbench



---
 rtl/fifo_flow_ctrl_pkg.sv | 13 +
 rtl/fifo_flow_ctrl_dpram.sv | 42 ++++
 rtl/fifo_flow_ctrl.sv | 151 +++++++++++++++
 tb/tb_fifo_flow_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flow_ctrl_pkg.sv
// Shared definitions for the flow-controlled FIFO: default geometry and the
// encoding of the back-pressure state machine.
package fifo_flow_ctrl_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic {
    ST_FLOW  = 1'b0,
    ST_PAUSE = 1'b1
  } pause_state_t;

endpackage

// File: rtl/fifo_flow_ctrl_dpram.sv
// Simple dual-port storage: synchronous write port and a registered read port
// whose output register holds its value when no read is enabled.
module fifo_flow_ctrl_dpram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // storage array write, contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read; a same-cycle write to rd_addr returns the old word
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Synchronous FIFO with guarded push/pop, sticky error flags and a hysteresis
// pause output that throttles the upstream lane logic.
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int THR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [THR_W-1:0]  umbral_bajo,
  input  logic [THR_W-1:0]  umbral_alto,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [THR_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              pause,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [THR_W-1:0] FULL_CNT = THR_W'(1) << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [THR_W-1:0]  count_r;
  logic [THR_W-1:0]  count_nxt_s;
  logic              valid_r;
  logic              ovf_r;
  logic              udf_r;
  logic              ovf_nxt_s;
  logic              udf_nxt_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              full_s;
  logic              empty_s;
  pause_state_t      state_r;
  pause_state_t      state_nxt_s;

  assign full_s   = (count_r == FULL_CNT);
  assign empty_s  = (count_r == {THR_W{1'b0}});
  // a push into a full FIFO is still legal when a pop frees a slot this cycle
  assign rd_acc_s = rd_en & ~empty_s;
  assign wr_acc_s = wr_en & (~full_s | rd_acc_s);

  fifo_flow_ctrl_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dpram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc_s & ~reset),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_en   (rd_acc_s & ~reset),
    .rd_addr (rd_ptr_r),
    .rd_data (data_out)
  );

  // occupancy, sticky-error and pause next-state computation
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    udf_nxt_s   = udf_r;
    state_nxt_s = state_r;

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + THR_W'(1);
      2'b01:   count_nxt_s = count_r - THR_W'(1);
      default: count_nxt_s = count_r;
    endcase

    if (wr_en & ~wr_acc_s) begin
      ovf_nxt_s = 1'b1;
    end else if (err_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    if (rd_en & ~rd_acc_s) begin
      udf_nxt_s = 1'b1;
    end else if (err_clr) begin
      udf_nxt_s = 1'b0;
    end else begin
      udf_nxt_s = udf_r;
    end

    case (state_r)
      ST_FLOW: begin
        if (count_r >= umbral_alto) begin
          state_nxt_s = ST_PAUSE;
        end else begin
          state_nxt_s = ST_FLOW;
        end
      end
      ST_PAUSE: begin
        if (count_r <= umbral_bajo) begin
          state_nxt_s = ST_FLOW;
        end else begin
          state_nxt_s = ST_PAUSE;
        end
      end
      default: state_nxt_s = ST_FLOW;
    endcase
  end

  // pointer, count, strobe, error and FSM state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {THR_W{1'b0}};
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      state_r  <= ST_FLOW;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= rd_acc_s;
      ovf_r   <= ovf_nxt_s;
      udf_r   <= udf_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign valid_out     = valid_r;
  assign count         = count_r;
  assign full          = full_s;
  assign empty         = empty_s;
  assign almost_full   = (count_r >= umbral_alto);
  assign almost_empty  = (count_r <= umbral_bajo);
  assign pause         = (state_r == ST_PAUSE);
  assign overflow_err  = ovf_r;
  assign underflow_err = udf_r;

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Scoreboard bench for fifo_flow_ctrl: expected pop data is queued when a pop
// is issued; a negedge monitor matches it against valid_out/data_out.
module tb_fifo_flow_ctrl;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [11:0] data_in;
  logic        rd_en;
  logic [3:0]  umbral_bajo;
  logic [3:0]  umbral_alto;
  logic        err_clr;
  logic [11:0] data_out;
  logic        valid_out;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        pause;
  logic        overflow_err;
  logic        underflow_err;

  typedef struct {
    logic [11:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  fifo_flow_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .data_in       (data_in),
    .rd_en         (rd_en),
    .umbral_bajo   (umbral_bajo),
    .umbral_alto   (umbral_alto),
    .err_clr       (err_clr),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .pause         (pause),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every negedge, the word due this cycle must be presented
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missed_pop: no valid_out for 0x%0h due at cycle %0d", exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("pop_valid", {31'd0, valid_out}, 32'd1);
        chk("pop_data", {20'd0, data_out}, {20'd0, exp_q[0].data});
        void'(exp_q.pop_front());
      end else if (valid_out === 1'b1) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_valid: valid_out=1 data 0x%0h, expected no pop (cycle %0d)", data_out, cyc);
      end
    end
  end

  // One clock cycle of stimulus; a pop expected to succeed queues its word
  task automatic step(input logic wr, input logic [11:0] d, input logic rd,
                      input logic exp_pop, input logic [11:0] exp_d, input logic clr);
    exp_t e;
    wr_en   = wr;
    data_in = d;
    rd_en   = rd;
    err_clr = clr;
    if (exp_pop) begin
      e.data = exp_d;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic push(input logic [11:0] d);
    step(1'b1, d, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  task automatic pop(input logic [11:0] exp_d);
    step(1'b0, 12'h000, 1'b1, 1'b1, exp_d, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    err_clr     = 1'b0;
    data_in     = 12'h000;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {20'd0, data_out}, 32'd0);
    chk("rst_pause", {31'd0, pause}, 32'd0);
    chk("rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);

    // fill and drain in order
    for (int i = 1; i <= 8; i++) push(12'(i));
    chk("fill_count", {28'd0, count}, 32'd8);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_afull", {31'd0, almost_full}, 32'd1);
    for (int i = 1; i <= 8; i++) pop(12'(i));
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("drain_count", {28'd0, count}, 32'd0);
    chk("drain_aempty", {31'd0, almost_empty}, 32'd1);

    // overflow: rejected push, sticky flag, cleared by err_clr
    for (int i = 0; i < 8; i++) push(12'h010 + 12'(i));
    push(12'hAAA);
    chk("ovf_set", {31'd0, overflow_err}, 32'd1);
    chk("ovf_count", {28'd0, count}, 32'd8);
    idle();
    chk("ovf_hold", {31'd0, overflow_err}, 32'd1);
    chk("full_pause", {31'd0, pause}, 32'd1);
    step(1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1);
    chk("ovf_clr", {31'd0, overflow_err}, 32'd0);

    // simultaneous push/pop while full
    for (int i = 0; i < 3; i++)
      step(1'b1, 12'h020 + 12'(i), 1'b1, 1'b1, 12'h010 + 12'(i), 1'b0);
    chk("fullrw_count", {28'd0, count}, 32'd8);
    chk("fullrw_noerr", {30'd0, overflow_err, underflow_err}, 32'd0);
    for (int i = 3; i < 8; i++) pop(12'h010 + 12'(i));
    for (int i = 0; i < 3; i++) pop(12'h020 + 12'(i));
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // empty: push accepted, pop rejected
    step(1'b1, 12'h055, 1'b1, 1'b0, 12'h000, 1'b0);
    chk("udf_count", {28'd0, count}, 32'd1);
    chk("udf_valid", {31'd0, valid_out}, 32'd0);
    chk("udf_set", {31'd0, underflow_err}, 32'd1);
    step(1'b0, 12'h000, 1'b1, 1'b1, 12'h055, 1'b1);
    chk("udf_clr", {31'd0, underflow_err}, 32'd0);

    // pause hysteresis with alto=6, bajo=2
    for (int i = 1; i <= 6; i++) push(12'h100 + 12'(i));
    chk("p6_count", {28'd0, count}, 32'd6);
    chk("p6_lag", {31'd0, pause}, 32'd0);
    idle();
    chk("p6_pause", {31'd0, pause}, 32'd1);
    for (int i = 1; i <= 3; i++) pop(12'h100 + 12'(i));
    idle();
    chk("p3_count", {28'd0, count}, 32'd3);
    chk("p3_pause", {31'd0, pause}, 32'd1);
    pop(12'h104);
    chk("p2_aempty", {31'd0, almost_empty}, 32'd1);
    chk("p2_lag", {31'd0, pause}, 32'd1);
    idle();
    chk("p2_flow", {31'd0, pause}, 32'd0);

    // reset mid-operation at count 5 (pause raised beforehand)
    for (int i = 0; i < 4; i++) push(12'h200 + 12'(i));
    idle();
    chk("pre_rst_pause", {31'd0, pause}, 32'd1);
    pop(12'h105);
    chk("pre_rst_count", {28'd0, count}, 32'd5);
    reset = 1'b1;
    step(1'b1, 12'h3FF, 1'b1, 1'b0, 12'h000, 1'b0);
    reset = 1'b0;
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_pause", {31'd0, pause}, 32'd0);
    chk("mid_rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    pop(12'h000);
    void'(exp_q.pop_back());
    chk("post_rst_udf", {31'd0, underflow_err}, 32'd1);

    repeat (3) idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
